// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and reconstructs the displayed hex digits.
// Optional stall watchdog enabled by defining FRAME_TIMEOUT_EN.
module seg_scan_decoder #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned STABLE_CYC  = 1000,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  glyph_err,
  output logic                  anode_err,
  output logic                  scan_stall
);

  localparam int unsigned CntW = $clog2(STABLE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

  // Returns {known, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  state_e              state;
  logic [6:0]          seg_r, seg_h;
  logic [DIGITS-1:0]   an_r, an_h;
  logic [CntW-1:0]     cnt;
  logic [DIGITS-1:0]   mask;
  logic [4*DIGITS-1:0] nib;
  logic                bad;
  logic                multi_q;

  logic [DIGITS-1:0]   sel;
  logic                multi, one, changed, hit, mask_full, cap_fire;
  logic [4:0]          glyph;

  always_comb begin
    sel       = ~an_r;
    multi     = |(sel & (sel - DIGITS'(1)));
    one       = (sel != '0) && !multi;
    changed   = (an_r != an_h) || (seg_r != seg_h);
    hit       = |(mask & sel);
    mask_full = &mask;
    glyph     = decode(seg_r);
    cap_fire  = (state == StCapture) && one && !changed;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);
  logic [WdW-1:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign scan_stall     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      seg_r       <= 7'h7F;
      seg_h       <= 7'h7F;
      an_r        <= '1;
      an_h        <= '1;
      cnt         <= '0;
      mask        <= '0;
      nib         <= '0;
      bad         <= 1'b0;
      multi_q     <= 1'b0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      glyph_err   <= 1'b0;
      anode_err   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      wd_cnt      <= '0;
      scan_stall  <= 1'b0;
`endif
    end else begin
      seg_r       <= seg;
      an_r        <= an;
      seg_h       <= seg_r;
      an_h        <= an_r;
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
      anode_err   <= 1'b0;
      multi_q     <= multi;
      if (multi && !multi_q) anode_err <= 1'b1;

      // Commit is always the cycle after the last capture, so it never races a capture.
      if (mask_full) begin
        value       <= nib;
        frame_valid <= 1'b1;
        frame_err   <= bad;
        mask        <= '0;
        bad         <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (one) begin
            state <= StSettle;
            cnt   <= '0;
          end
        end
        StSettle: begin
          if (!one) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (changed) begin
            cnt <= '0;
          end else if (cnt == CntMax) begin
            state <= StCapture;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StCapture: begin
          if (!one) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (changed) begin
            state <= StSettle;
            cnt   <= '0;
          end else begin
            state <= StHold;
            if (!hit) begin
              for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) nib[4*i +: 4] <= glyph[3:0];
              end
              mask <= mask | sel;
              if (!glyph[4]) begin
                glyph_err <= 1'b1;
                bad       <= 1'b1;
              end
            end
          end
        end
        StHold: begin
          if (!one) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (changed) begin
            state <= StSettle;
            cnt   <= '0;
          end
        end
        default: state <= StIdle;
      endcase

`ifdef FRAME_TIMEOUT_EN
      if (cap_fire) begin
        wd_cnt     <= '0;
        scan_stall <= 1'b0;
      end else if (wd_cnt == WdMax) begin
        scan_stall <= 1'b1;
        mask       <= '0;
        bad        <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + WdW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frame assembly, glyph/anode errors, bounce,
// async reset and (when FRAME_TIMEOUT_EN is defined) the stall watchdog.
module tb_seg_scan_decoder;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] value;
  logic        frame_valid, frame_err, glyph_err, anode_err, scan_stall;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int ge_cnt = 0;
  int ae_cnt = 0;
  logic last_ferr = 1'b0;
  int fv0, ge0, ae0;

  seg_scan_decoder #(
    .DIGITS     (3),
    .STABLE_CYC (S),
    .TIMEOUT_CYC(5000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .value      (value),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .glyph_err  (glyph_err),
    .anode_err  (anode_err),
    .scan_stall (scan_stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        fv_cnt++;
        last_ferr = frame_err;
      end
      if (glyph_err) ge_cnt++;
      if (anode_err) ae_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    fv0 = fv_cnt;
    ge0 = ge_cnt;
    ae0 = ae_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 3'b111;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_fv", 32'(frame_valid), 32'h0);
    check_eq("rst_ge", 32'(glyph_err), 32'h0);
    check_eq("rst_ae", 32'(anode_err), 32'h0);
    check_eq("rst_stall", 32'(scan_stall), 32'h0);

    // Plain scan
    mark();
    drive(3'b111, 7'h7F, 4);
    drive(3'b110, 7'h40, 2*S);
    drive(3'b101, 7'h79, 2*S);
    drive(3'b011, 7'h24, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t1_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t1_value", 32'(value), 32'h210);
    check_eq("t1_ferr", 32'(last_ferr), 32'h0);
    check_eq("t1_ae", 32'(ae_cnt - ae0), 32'd0);

    // Long dwell on digit 0
    mark();
    drive(3'b110, 7'h19, 10*S);
    drive(3'b101, 7'h30, 2*S);
    drive(3'b011, 7'h12, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t2_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t2_value", 32'(value), 32'h534);

    // Blank glyph on digit 0
    mark();
    drive(3'b110, 7'h7F, 2*S);
    drive(3'b101, 7'h02, 2*S);
    drive(3'b011, 7'h78, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t3_ge", 32'(ge_cnt - ge0), 32'd1);
    check_eq("t3_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t3_ferr", 32'(last_ferr), 32'h1);
    check_eq("t3_value", 32'(value), 32'h760);

    // Two anodes low mid-frame
    mark();
    drive(3'b110, 7'h08, 2*S);
    drive(3'b100, 7'h00, 50);
    check_eq("t4_fv_mid", 32'(fv_cnt - fv0), 32'd0);
    drive(3'b101, 7'h03, 2*S);
    drive(3'b011, 7'h46, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t4_ae", 32'(ae_cnt - ae0), 32'd1);
    check_eq("t4_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t4_value", 32'(value), 32'hCBA);
    check_eq("t4_ferr", 32'(last_ferr), 32'h0);

    // Bouncing segments on digit 1 must not latch the transient glyph
    mark();
    drive(3'b110, 7'h21, 2*S);
    for (int i = 0; i < 6; i++) drive(3'b101, (i % 2 == 0) ? 7'h06 : 7'h0E, S/2);
    drive(3'b101, 7'h0E, 2*S);
    drive(3'b011, 7'h10, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t5_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t5_value", 32'(value), 32'h9FD);

    // Async reset mid-frame discards partial progress
    drive(3'b110, 7'h40, 2*S);
    drive(3'b101, 7'h79, 2*S);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_value", 32'(value), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    drive(3'b011, 7'h19, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("rst_partial_fv", 32'(fv_cnt - fv0), 32'd0);
    drive(3'b110, 7'h30, 2*S);
    drive(3'b101, 7'h12, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("rst_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("rst_frame_value", 32'(value), 32'h453);

`ifdef FRAME_TIMEOUT_EN
    drive(3'b110, 7'h79, 2*S);
    drive(3'b101, 7'h79, 2*S);
    drive(3'b111, 7'h7F, 6000);
    check_eq("t6_stall_hi", 32'(scan_stall), 32'h1);
    mark();
    drive(3'b110, 7'h40, 2*S);
    drive(3'b101, 7'h24, 2*S);
    drive(3'b011, 7'h30, 2*S);
    drive(3'b111, 7'h7F, 8);
    check_eq("t6_stall_lo", 32'(scan_stall), 32'h0);
    check_eq("t6_fv", 32'(fv_cnt - fv0), 32'd1);
    check_eq("t6_value", 32'(value), 32'h320);
`else
    drive(3'b111, 7'h7F, 200);
    check_eq("t6_no_stall", 32'(scan_stall), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
